// File: rtl/ri_k_calc_pkg.sv
// Shared definitions for the run-interruption Golomb-k calculator:
// FSM state encoding, default widths, the run-mode code and the k search limit.
package ri_k_calc_pkg;

  localparam int A_LENGTH_DEF    = 13;
  localparam int N_LENGTH_DEF    = 7;
  localparam int MODE_LENGTH_DEF = 2;
  localparam int RUN_MODE_DEF    = 2;
  localparam int K_MAX_DEF       = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ri_temp_unit.sv
// Combinational auxiliary-variable unit: temp = A (+ N/2 for RIType=1) in run mode,
// zero otherwise. Operands are zero-extended so the sum never truncates.
module ri_temp_unit
  import ri_k_calc_pkg::*;
#(
  parameter int A_LENGTH    = A_LENGTH_DEF,
  parameter int N_LENGTH    = N_LENGTH_DEF,
  parameter int TEMP_LENGTH = A_LENGTH + 1,
  parameter int MODE_LENGTH = MODE_LENGTH_DEF,
  parameter int RUN_MODE    = RUN_MODE_DEF
) (
  input  logic [A_LENGTH-1:0]    a_select,
  input  logic [N_LENGTH-1:0]    n_select,
  input  logic                   ri_type,
  input  logic [MODE_LENGTH-1:0] mode,
  output logic [TEMP_LENGTH-1:0] temp
);

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    temp = '0;
    if (mode == MODE_LENGTH'(RUN_MODE)) begin
      if (ri_type) begin
        temp = TEMP_LENGTH'(a_select) + TEMP_LENGTH'(n_select >> 1);
      end else begin
        temp = TEMP_LENGTH'(a_select);
      end
    end
  end

endmodule

// File: rtl/ri_k_calc.sv
// Golomb-k search for run-interruption coding: smallest k with (N << k) >= temp.
// Define RI_K_EARLY_EXIT_EN to leave the search at the first passing k; otherwise it always runs K_MAX+1 cycles.
module ri_k_calc
  import ri_k_calc_pkg::*;
#(
  parameter int A_LENGTH    = A_LENGTH_DEF,
  parameter int N_LENGTH    = N_LENGTH_DEF,
  parameter int TEMP_LENGTH = A_LENGTH + 1,
  parameter int MODE_LENGTH = MODE_LENGTH_DEF,
  parameter int RUN_MODE    = RUN_MODE_DEF,
  parameter int K_MAX       = K_MAX_DEF,
  parameter int K_LENGTH    = $clog2(K_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [A_LENGTH-1:0]    A_Select,
  input  logic [N_LENGTH-1:0]    N_Select,
  input  logic                   RIType,
  input  logic [MODE_LENGTH-1:0] mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TEMP_LENGTH-1:0] temp,
  output logic [K_LENGTH-1:0]    k,
  output logic                   k_sat
);

  // Wide enough that N shifted by K_MAX never loses bits against temp.
  localparam int CMP_W = TEMP_LENGTH + K_MAX;

  state_t                 state_q, state_d;
  logic [TEMP_LENGTH-1:0] temp_calc;
  logic [N_LENGTH-1:0]    n_q;
  logic [K_LENGTH-1:0]    k_cnt;
  logic                   found_q;
  logic [CMP_W-1:0]       n_ext, temp_ext;
  logic                   pass, last;

  ri_temp_unit #(
    .A_LENGTH    (A_LENGTH),
    .N_LENGTH    (N_LENGTH),
    .TEMP_LENGTH (TEMP_LENGTH),
    .MODE_LENGTH (MODE_LENGTH),
    .RUN_MODE    (RUN_MODE)
  ) u_temp (
    .a_select (A_Select),
    .n_select (N_Select),
    .ri_type  (RIType),
    .mode     (mode),
    .temp     (temp_calc)
  );

  assign n_ext    = CMP_W'(n_q);
  assign temp_ext = CMP_W'(temp);
  assign pass     = (n_ext << k_cnt) >= temp_ext;
  assign last     = (k_cnt == K_LENGTH'(K_MAX));

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = CALC;
      CALC: begin
`ifdef RI_K_EARLY_EXIT_EN
        if (pass || last) state_d = DONE;
`else
        if (last) state_d = DONE;
`endif
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the values present before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      temp    <= '0;
      n_q     <= '0;
      k_cnt   <= '0;
      k       <= '0;
      k_sat   <= 1'b0;
      found_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            temp    <= temp_calc;
            n_q     <= N_Select;
            k_cnt   <= '0;
            k       <= '0;
            k_sat   <= 1'b0;
            found_q <= 1'b0;
          end
        end
        CALC: begin
          if (!last) k_cnt <= k_cnt + 1'b1;
          // Only the first passing candidate is kept; later passes are ignored.
          if (pass && !found_q) begin
            k       <= k_cnt;
            found_q <= 1'b1;
          end else if (last && !found_q) begin
            k     <= K_LENGTH'(K_MAX);
            k_sat <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ri_k_calc.sv
// Self-checking bench for ri_k_calc: directed cases with literal expectations plus
// randomized operands checked every cycle against an arithmetic reference model.
module tb_ri_k_calc;

  localparam int A_W   = 13;
  localparam int N_W   = 7;
  localparam int T_W   = 14;
  localparam int M_W   = 2;
  localparam int RUN   = 2;
  localparam int K_MX  = 16;
  localparam int K_W   = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid, in_ready;
  logic [A_W-1:0] A_Select;
  logic [N_W-1:0] N_Select;
  logic           RIType;
  logic [M_W-1:0] mode;
  logic           out_valid, out_ready;
  logic [T_W-1:0] temp;
  logic [K_W-1:0] k;
  logic           k_sat;

  ri_k_calc dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A_Select  (A_Select),
    .N_Select  (N_Select),
    .RIType    (RIType),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .temp      (temp),
    .k         (k),
    .k_sat     (k_sat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // Reference model straight from the rules: temp by case, k by trying each candidate.
  function automatic void model(input int a, input int n, input int ri, input int md,
                                output int t, output int kk, output int sat, output int lat);
    t   = (md != RUN) ? 0 : (ri != 0 ? a + n / 2 : a);
    kk  = K_MX;
    sat = 1;
    for (int j = 0; j <= K_MX; j++) begin
      if (sat == 1 && (longint'(n) * (longint'(1) << j)) >= longint'(t)) begin
        kk  = j;
        sat = 0;
      end
    end
`ifdef RI_K_EARLY_EXIT_EN
    lat = kk + 2;
`else
    lat = K_MX + 2;
`endif
  endfunction

  // Expectations for the operation in flight, consumed by the compare process.
  bit exp_active = 1'b0;
  bit exp_ov;
  int exp_temp, exp_k, exp_sat, exp_lat, exp_done_cyc, acc_cyc;
  int got_temp, got_k, got_sat, got_lat;

  always @(negedge clk) begin
    if (exp_active) begin
      exp_ov = (cyc >= exp_done_cyc);
      check("out_valid", out_valid, exp_ov);
      check("in_ready_busy", in_ready, 1'b0);
      if (exp_ov) begin
        check("temp", temp, exp_temp);
        check("k", k, exp_k);
        check("k_sat", k_sat, exp_sat);
      end
    end
  end

  task automatic scramble();
    A_Select = A_W'($urandom);
    N_Select = N_W'($urandom);
    RIType   = 1'($urandom);
    mode     = M_W'($urandom);
  endtask

  task automatic accept(input int a, input int n, input int ri, input int md);
    @(negedge clk);
    A_Select = A_W'(a);
    N_Select = N_W'(n);
    RIType   = 1'(ri);
    mode     = M_W'(md);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    model(a, n, ri, md, exp_temp, exp_k, exp_sat, exp_lat);
    acc_cyc      = cyc;
    exp_done_cyc = cyc + exp_lat - 1;
    exp_active   = 1'b1;
    in_valid     = 1'b0;
    scramble();
  endtask

  task automatic run_op(input int a, input int n, input int ri, input int md,
                        input int hold, input bit poke);
    bit done = 1'b0;
    accept(a, n, ri, md);
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (out_valid) done = 1'b1;
    end
    if (!done) check("out_valid_timeout", 1'b0, 1'b1);
    got_temp = int'(temp);
    got_k    = int'(k);
    got_sat  = int'(k_sat);
    got_lat  = cyc - acc_cyc + 1;
    check("latency", got_lat, exp_lat);
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    if (poke) in_valid = 1'b1;
    @(posedge clk);
    #1;
    exp_active = 1'b0;
    out_ready  = 1'b0;
    @(negedge clk);
    check("in_ready_after_release", in_ready, 1'b1);
    check("out_valid_after_release", out_valid, 1'b0);
    in_valid = 1'b0;
  endtask

  task automatic reset_after(input int edges);
    accept(20, 4, 1, RUN);
    repeat (edges) @(posedge clk);
    #1;
    exp_active = 1'b0;
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_temp", temp, 0);
    check("rst_k", k, 0);
    check("rst_k_sat", k_sat, 1'b0);
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    int a, n, ri, md, hold;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    scramble();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_temp", temp, 0);
    check("reset_k", k, 0);
    check("reset_k_sat", k_sat, 1'b0);
    reset = 1'b0;

    run_op(20, 4, 1, 2, 0, 1'b0);
    check("lit_ri1_temp", got_temp, 22);
    check("lit_ri1_k", got_k, 3);
    check("lit_ri1_sat", got_sat, 0);
`ifdef RI_K_EARLY_EXIT_EN
    check("lit_ri1_lat", got_lat, 5);
`else
    check("lit_ri1_lat", got_lat, 18);
`endif

    run_op(20, 4, 0, 2, 1, 1'b1);
    check("lit_ri0_temp", got_temp, 20);
    check("lit_ri0_k", got_k, 3);
    check("lit_ri0_sat", got_sat, 0);

    run_op(20, 4, 0, 1, 0, 1'b0);
    check("lit_mode1_temp", got_temp, 0);
    check("lit_mode1_k", got_k, 0);
    check("lit_mode1_sat", got_sat, 0);
`ifdef RI_K_EARLY_EXIT_EN
    check("lit_mode1_lat", got_lat, 2);
`else
    check("lit_mode1_lat", got_lat, 18);
`endif

    run_op(5, 0, 0, 2, 0, 1'b0);
    check("lit_n0_temp", got_temp, 5);
    check("lit_n0_k", got_k, 16);
    check("lit_n0_sat", got_sat, 1);

    // Long back-pressure: the compare process checks stability every held cycle.
    run_op(8191, 127, 1, 2, 10, 1'b1);
    check("lit_max_temp", got_temp, 8254);
    check("lit_max_k", got_k, 7);

    run_op(8191, 1, 0, 2, 0, 1'b0);
    check("lit_n1_k", got_k, 13);

    run_op(0, 0, 0, 2, 0, 1'b0);
    check("lit_zero_k", got_k, 0);
    check("lit_zero_sat", got_sat, 0);

    reset_after(1);
    run_op(20, 4, 1, 2, 0, 1'b0);
    check("post_rst_temp", got_temp, 22);
    check("post_rst_k", got_k, 3);

    reset_after(20);
    run_op(100, 3, 1, 2, 2, 1'b0);

    for (int i = 0; i < 30; i++) begin
      a    = (i % 7 == 0) ? 8191 : int'($urandom_range(0, 8191));
      n    = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 127));
      ri   = int'($urandom_range(0, 1));
      md   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : RUN;
      hold = int'($urandom_range(0, 3));
      run_op(a, n, ri, md, hold, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ri_k_calc.md
RI_K_CALC -- requirements
Module: ri_k_calc

Interface
REQ-001 SHALL have parameter A_LENGTH, default 13, width of accumulated-error magnitude A.
REQ-002 SHALL have parameter N_LENGTH, default 7, width of context occurrence count N.
REQ-003 SHALL have parameter TEMP_LENGTH, default A_LENGTH+1, width of auxiliary variable temp.
REQ-004 SHALL have parameter MODE_LENGTH, default 2, width of coding-mode code.
REQ-005 SHALL have parameter RUN_MODE, default 2, mode code meaning run-interruption coding.
REQ-006 SHALL have parameter K_MAX, default 16, maximum Golomb k; K_LENGTH = clog2(K_MAX+1).
REQ-007 SHALL have one clock and a synchronous, active-high reset; no other clock or reset.
REQ-008 clk  input  1  rising-edge clock.
REQ-009 reset  input  1  synchronous active-high reset.
REQ-010 in_valid  input  1  input operands valid.
REQ-011 in_ready  output  1  block can accept operands.
REQ-012 A_Select  input  A_LENGTH  selected context A.
REQ-013 N_Select  input  N_LENGTH  selected context N.
REQ-014 RIType  input  1  run-interruption type.
REQ-015 mode  input  MODE_LENGTH  current coding mode.
REQ-016 out_valid  output  1  result valid.
REQ-017 out_ready  input  1  consumer accepts result.
REQ-018 temp  output  TEMP_LENGTH  registered auxiliary variable.
REQ-019 k  output  K_LENGTH  registered Golomb parameter.
REQ-020 k_sat  output  1  k clamped at K_MAX without meeting condition.

Function
REQ-021 temp SHALL be 0 when mode != RUN_MODE; A_Select + (N_Select >> 1) when RIType=1; A_Select when RIType=0; operands zero-extended to TEMP_LENGTH, no truncation.
REQ-022 k SHALL be the smallest value 0..K_MAX with (N << k) >= temp, compared at TEMP_LENGTH+K_MAX bits; temp=0 gives k=0.
REQ-023 If no k <= K_MAX satisfies REQ-022 (including N=0, temp>0), k SHALL be K_MAX and k_sat SHALL be 1; otherwise k_sat SHALL be 0.
REQ-024 FSM states SHALL be IDLE, CALC, DONE.
REQ-025 IDLE: in_ready=1; on in_valid, latch operands, compute temp, clear k counter, go to CALC.
REQ-026 CALC: one k candidate tested per cycle, starting at 0 and incrementing by 1.
REQ-027 DONE: out_valid=1, temp/k/k_sat held stable; on out_ready go to IDLE.
REQ-028 in_ready SHALL be 0 outside IDLE; no new operand accepted in the DONE->IDLE cycle.
REQ-029 Input changes while not in IDLE SHALL not affect the result in flight.

Reset
REQ-030 reset SHALL force IDLE next edge, discarding any in-flight operation, including mid-CALC or in DONE with out_ready=0.
REQ-031 Reset values: in_ready=1 after first post-reset edge; out_valid=0, temp=0, k=0, k_sat=0.
REQ-032 reset SHALL dominate in_valid and out_ready in the same cycle.

Configuration
REQ-033 Macro RI_K_EARLY_EXIT_EN SHALL select search termination.
REQ-034 Defined: CALC exits to DONE on first passing k or at k=K_MAX; accept-to-out_valid latency = k+2 cycles.
REQ-035 Undefined: CALC always runs K_MAX+1 cycles, latching the first passing k; latency = K_MAX+2 cycles fixed; results identical to defined case.

Structure
REQ-036 Shared package SHALL hold the FSM state enum, default widths, RUN_MODE code and K_MAX constant.
REQ-037 temp arithmetic SHALL be one combinational sub-module, ri_temp_unit; FSM and k search stay in ri_k_calc.

Verification
REQ-038 A=20, N=4, RIType=1, mode=2 -> temp=22, k=3, k_sat=0; out_valid 5 cycles after accept (early exit) or 18 (without).
REQ-039 A=20, N=4, RIType=0, mode=2 -> temp=20, k=3, k_sat=0.
REQ-040 A=20, N=4, mode=1 -> temp=0, k=0, k_sat=0; out_valid 2 cycles after accept (early exit).
REQ-041 A=5, N=0, RIType=0, mode=2 -> temp=5, k=16, k_sat=1.
REQ-042 out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready=0; then out_ready=1 -> IDLE next edge.
REQ-043 reset asserted in 2nd CALC cycle -> next edge IDLE, out_valid=0, temp=k=k_sat=0; next operand processed correctly.
